debug_initiator: RTL



---
 rtl/debug_initiator_if.sv | 26 ++
 rtl/debug_initiator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/debug_initiator_if.sv
// Debug initiator bus: host control, target command/response, and the result stream.
// The master modport belongs to the initiator; the slave modport belongs to whatever drives it.
interface debug_initiator_if;
  logic       start;
  logic [1:0] mode;
  logic       dbg_en;
  logic [7:0] cmd_out;
  logic [7:0] rsp_in;
  logic [7:0] rsp_oe;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, mode, rsp_in, rsp_oe, res_ready,
    output dbg_en, cmd_out, res_valid, res_data, busy, done, err
  );

  modport slave (
    output start, mode, rsp_in, rsp_oe, res_ready,
    input  dbg_en, cmd_out, res_valid, res_data, busy, done, err
  );
endinterface

// File: rtl/debug_initiator.sv
// Debug-port initiator: issues board/column/winner reads to a target over the uio bus and
// streams the decoded results through a valid/ready handshake.
module debug_initiator #(
  parameter int unsigned ROWS        = 6,
  parameter int unsigned COLS        = 7,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  debug_initiator_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StSample,
    StPush,
    StDone
  } state_e;

  localparam logic [2:0] RowLast  = 3'(ROWS - 1);
  localparam logic [2:0] ColLast  = 3'(COLS - 1);
  localparam logic [2:0] WaitLast = 3'(WAIT_CYCLES - 1);
  localparam logic [7:0] OeDriven = 8'hFC;

  localparam logic [1:0] ModeBoard  = 2'd1;
  localparam logic [1:0] ModeColumn = 2'd2;
  localparam logic [1:0] ModeWinner = 2'd3;

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dbg_en_q, dbg_en_d;
  logic [7:0] cmd_q, cmd_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_data_q, res_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       last_cell;

  assign last_cell = (row_q == RowLast) && (col_q == ColLast);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    dbg_en_d    = dbg_en_q;
    cmd_d       = cmd_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.mode != 2'd0) begin
            state_d  = StIssue;
            mode_d   = bus.mode;
            row_d    = 3'd0;
            col_d    = 3'd0;
            busy_d   = 1'b1;
            dbg_en_d = 1'b1;
            err_d    = 1'b0;
          end else begin
            // Illegal request: report and finish without touching the target.
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      StIssue: begin
        cmd_d   = {row_q, col_q, mode_q};
        cnt_d   = 3'd0;
        state_d = StWait;
      end

      StWait: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == WaitLast) begin
          state_d = StSample;
        end
      end

      StSample: begin
        if (bus.rsp_oe != OeDriven) begin
          err_d = 1'b1;
        end
        unique case (mode_q)
          ModeBoard:  res_data_d = {row_q, col_q, bus.rsp_in[7:6]};
          ModeColumn: res_data_d = {5'b0, bus.rsp_in[7:5]};
          ModeWinner: res_data_d = {6'b0, bus.rsp_in[7:6]};
          default:    res_data_d = res_data_q;
        endcase
        res_valid_d = 1'b1;
        state_d     = StPush;
      end

      StPush: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if ((mode_q == ModeBoard) && !last_cell) begin
            if (col_q == ColLast) begin
              col_d = 3'd0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 3'd1;
            end
            state_d = StIssue;
          end else begin
            state_d  = StDone;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            dbg_en_d = 1'b0;
            cmd_d    = 8'h00;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= 2'd0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      cnt_q       <= 3'd0;
      dbg_en_q    <= 1'b0;
      cmd_q       <= 8'h00;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      dbg_en_q    <= dbg_en_d;
      cmd_q       <= cmd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.dbg_en    = dbg_en_q;
  assign bus.cmd_out   = cmd_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
